clock_set_ctrl: RTL

//  Front-panel sequencer for the calendar clock. Turns three raw buttons (Mode/Sel/Adv) into the

---
 rtl/clock_pkg.sv | 36 +++
 rtl/btn_edge.sv | 22 ++
 rtl/clock_set_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the calendar clock front panel.
// Mode and field encodings are visible on the Mode/Field ports of clock_set_ctrl.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SET_TIME  = 2'd1,
    SET_ALARM = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    F_MIN  = 3'd0,
    F_HRS  = 3'd1,
    F_DAY  = 3'd2,
    F_DATE = 3'd3,
    F_MON  = 3'd4
  } field_t;

  localparam int NS = 60;
  localparam int NH = 24;
  localparam int ND = 7;
  localparam int NM = 12;

  // The alarm has no date or month, so its field ring stops at the weekday.
  function automatic field_t field_max(input mode_t m);
    return (m == SET_ALARM) ? F_DAY : F_MON;
  endfunction

  function automatic field_t field_succ(input field_t f, input mode_t m);
    if (f == field_max(m)) begin
      return F_MIN;
    end
    return field_t'(f + 3'd1);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one panel button.
// The history flop resets to 1 so a button held through reset never produces an edge.
module btn_edge (
  input  logic clk,
  input  logic srst,
  input  logic btn,
  output logic rise
);

  logic btn_q_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      btn_q_reg <= 1'b1;
    end else begin
      btn_q_reg <= btn;
    end
  end

  assign rise = btn & ~btn_q_reg;

endmodule

// File: rtl/clock_set_ctrl.sv
// Front-panel sequencer: Mode/Sel/Adv buttons -> set-mode levels and field-advance strobes.
// Build macro AUTO_REPEAT_EN adds hold-to-repeat advances on AdvBtn.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int IDLE_TO = 30,
  parameter int RPT_DLY = 4,
  parameter int RPT_PER = 2
) (
  input  logic       Pulse,
  input  logic       Reset,
  input  logic       ModeBtn,
  input  logic       SelBtn,
  input  logic       AdvBtn,
  output logic       Timeset,
  output logic       Alarmset,
  output logic       Minadv,
  output logic       Hrsadv,
  output logic       Dayadv,
  output logic       Datadv,
  output logic       Monadv,
  output logic [1:0] Mode,
  output logic [2:0] Field
);

  localparam int IDLE_W = $clog2(IDLE_TO);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TO - 1);

  if (IDLE_TO < 2 || RPT_DLY < 1 || RPT_PER < 1) begin : g_param_check
    $error("clock_set_ctrl: need IDLE_TO >= 2, RPT_DLY >= 1, RPT_PER >= 1");
  end

  logic [2:0] btn_raw;
  logic [2:0] btn_rise;
  logic       mode_rise;
  logic       sel_rise;
  logic       adv_rise;

  mode_t             mode_reg, mode_next;
  field_t            field_reg, field_next;
  logic [IDLE_W-1:0] idle_reg, idle_next;
  logic              timeset_reg, alarmset_reg;
  logic [4:0]        adv_reg, adv_next;
  logic              adv_fire;
  logic              event_acc;
  logic              rpt_fire;

  assign btn_raw = {AdvBtn, SelBtn, ModeBtn};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      btn_edge u_edge (
        .clk  (Pulse),
        .srst (Reset),
        .btn  (btn_raw[gi]),
        .rise (btn_rise[gi])
      );
    end
  endgenerate

  assign mode_rise = btn_rise[0];
  assign sel_rise  = btn_rise[1];
  assign adv_rise  = btn_rise[2];

  // Only the highest-priority edge is honoured; an accepted event restarts the idle count,
  // and it also beats a timeout landing in the same cycle.
  always_comb begin
    mode_next  = mode_reg;
    field_next = field_reg;
    idle_next  = idle_reg;
    adv_fire   = 1'b0;
    event_acc  = 1'b0;
    if (mode_reg == RUN) begin
      idle_next = '0;
      if (mode_rise) begin
        mode_next  = SET_TIME;
        field_next = F_MIN;
      end
    end else begin
      if (mode_rise) begin
        mode_next  = (mode_reg == SET_TIME) ? SET_ALARM : RUN;
        field_next = F_MIN;
        event_acc  = 1'b1;
      end else if (sel_rise) begin
        field_next = field_succ(field_reg, mode_reg);
        event_acc  = 1'b1;
      end else if (adv_rise || rpt_fire) begin
        adv_fire  = 1'b1;
        event_acc = 1'b1;
      end

      if (event_acc) begin
        idle_next = '0;
      end else if (idle_reg == IDLE_LAST) begin
        mode_next  = RUN;
        field_next = F_MIN;
        idle_next  = '0;
      end else begin
        idle_next = idle_reg + IDLE_W'(1);
      end
    end
  end

  // One strobe per field; date and month only exist while setting the time.
  generate
    for (gi = 0; gi < 5; gi++) begin : g_adv
      if (gi < 3) begin : g_common
        assign adv_next[gi] = adv_fire && (field_reg == 3'(gi));
      end else begin : g_time_only
        assign adv_next[gi] = adv_fire && (field_reg == 3'(gi)) && (mode_reg == SET_TIME);
      end
    end
  endgenerate

  always_ff @(posedge Pulse) begin
    if (Reset) begin
      mode_reg     <= RUN;
      field_reg    <= F_MIN;
      idle_reg     <= '0;
      timeset_reg  <= 1'b0;
      alarmset_reg <= 1'b0;
      adv_reg      <= '0;
    end else begin
      mode_reg     <= mode_next;
      field_reg    <= field_next;
      idle_reg     <= idle_next;
      timeset_reg  <= (mode_next == SET_TIME);
      alarmset_reg <= (mode_next == SET_ALARM);
      adv_reg      <= adv_next;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic             rpt_active_reg;
  logic             rpt_first_reg;
  logic [RPT_W-1:0] rpt_cnt_reg;
  logic             adv_start;

  // rpt_cnt_reg counts held cycles since the last advance; the first gap is RPT_DLY long.
  assign rpt_fire  = rpt_active_reg && AdvBtn &&
                     (rpt_cnt_reg == (rpt_first_reg ? RPT_W'(RPT_DLY) : RPT_W'(RPT_PER)));
  assign adv_start = adv_fire && adv_rise;

  always_ff @(posedge Pulse) begin
    if (Reset) begin
      rpt_active_reg <= 1'b0;
      rpt_first_reg  <= 1'b0;
      rpt_cnt_reg    <= '0;
    end else if (adv_start) begin
      rpt_active_reg <= 1'b1;
      rpt_first_reg  <= 1'b1;
      rpt_cnt_reg    <= RPT_W'(1);
    end else if (!rpt_active_reg || !AdvBtn || mode_rise || sel_rise || mode_next == RUN) begin
      rpt_active_reg <= 1'b0;
    end else if (rpt_fire) begin
      rpt_first_reg <= 1'b0;
      rpt_cnt_reg   <= RPT_W'(1);
    end else begin
      rpt_cnt_reg <= rpt_cnt_reg + RPT_W'(1);
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign Timeset  = timeset_reg;
  assign Alarmset = alarmset_reg;
  assign Minadv   = adv_reg[F_MIN];
  assign Hrsadv   = adv_reg[F_HRS];
  assign Dayadv   = adv_reg[F_DAY];
  assign Datadv   = adv_reg[F_DATE];
  assign Monadv   = adv_reg[F_MON];
  assign Mode     = mode_reg;
  assign Field    = field_reg;

endmodule
